// File: rtl/featuremap_conv_scheduler_if.sv
// Control bundle between the conv scheduler, the channel input FIFOs and the
// conv2D engines. Data words travel elsewhere.
interface featuremap_conv_scheduler_if #(
    parameter int unsigned WIDTH    = 56,
    parameter int unsigned HEIGHT   = 56,
    parameter int unsigned CHANNELS = 16
);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 2);
    localparam int unsigned COL_W = $clog2(WIDTH + 2);

    logic                start;
    logic [CHANNELS-1:0] fifo_empty;
    logic                stall;
    logic                result_valid;
    logic                fifo_rdreq;
    logic                conv_valid;
    logic                pad_sel;
    logic                busy;
    logic                done;
    logic [ROW_W-1:0]    row_cnt;
    logic [COL_W-1:0]    col_cnt;

    // master: the scheduler itself; slave: the surrounding layer datapath
    modport master (
        input  start, fifo_empty, stall, result_valid,
        output fifo_rdreq, conv_valid, pad_sel, busy, done, row_cnt, col_cnt
    );

    modport slave (
        output start, fifo_empty, stall, result_valid,
        input  fifo_rdreq, conv_valid, pad_sel, busy, done, row_cnt, col_cnt
    );
endinterface

// File: rtl/featuremap_conv_scheduler.sv
// Raster scan of one zero-padded feature-map frame: pops the channel FIFOs on
// interior positions, injects zero padding on the border, counts results.
module featuremap_conv_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIDTH      = 56,
    parameter int unsigned HEIGHT     = 56,
    parameter int unsigned CHANNELS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    featuremap_conv_scheduler_if.master    bus
);
    localparam int unsigned ROW_W     = $clog2(HEIGHT + 2);
    localparam int unsigned COL_W     = $clog2(WIDTH + 2);
    localparam int unsigned RES_TOTAL = WIDTH * HEIGHT;
    localparam int unsigned RES_W     = $clog2(RES_TOTAL + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);
    localparam logic [RES_W-1:0] RES_FULL = RES_W'(RES_TOTAL);

    // DATA_WIDTH only keeps the parameter list aligned with the filter instances
    if (DATA_WIDTH == 0) begin : g_invalid_data_width
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [RES_W-1:0]    res_q, res_d;
    logic [CHANNELS-1:0] fifo_empty;
    logic                border, all_ready, in_scan, last_pos;
    logic                conv_valid, pad_sel, fifo_rdreq;

    assign fifo_empty = bus.fifo_empty;

    always_comb begin
        in_scan    = (state_q == SCAN);
        border     = (row_q == '0) || (row_q == ROW_LAST) ||
                     (col_q == '0) || (col_q == COL_LAST);
        all_ready  = (fifo_empty == '0);
        last_pos   = (row_q == ROW_LAST) && (col_q == COL_LAST);
        conv_valid = in_scan && !bus.stall && (border || all_ready);
        pad_sel    = border && conv_valid;
        fifo_rdreq = in_scan && !border && all_ready && !bus.stall;

        // result counter saturates; its next value also decides DRAIN exit
        res_d = res_q;
        if (state_q == IDLE && bus.start) begin
            res_d = '0;
        end else if ((state_q == SCAN || state_q == DRAIN) &&
                     bus.result_valid && res_q != RES_FULL) begin
            res_d = res_q + RES_W'(1);
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN:    if (conv_valid && last_pos) state_d = DRAIN;
            DRAIN:   if (res_d == RES_FULL) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (state_q == IDLE && bus.start) begin
                row_q <= '0;
                col_q <= '0;
            end else if (conv_valid && !last_pos) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    assign bus.conv_valid = conv_valid;
    assign bus.pad_sel    = pad_sel;
    assign bus.fifo_rdreq = fifo_rdreq;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.row_cnt    = row_q;
    assign bus.col_cnt    = col_q;
endmodule

// File: tb/tb_featuremap_conv_scheduler.sv
// Directed plus randomized frames against a position/result-count reference
// model of the padded raster scan (WIDTH=4, HEIGHT=3).
module tb_featuremap_conv_scheduler;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int GW   = W + 2;
    localparam int GH   = H + 2;
    localparam int NPOS = GW * GH;
    localparam int NRES = W * H;
    localparam int NPAD = 2 * GW + 2 * H;

    logic clk = 1'b0;
    logic rst = 1'b1;

    featuremap_conv_scheduler_if #(.WIDTH(W), .HEIGHT(H), .CHANNELS(16)) bus ();

    featuremap_conv_scheduler #(
        .DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H), .CHANNELS(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: frame activity, scan position index, results received
    bit m_active, m_complete, m_done;
    int m_pos, m_results;
    int n_cv, n_rd, n_pad, first_rd_row, first_rd_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_border(input int p);
        int r, c;
        r = p / GW;
        c = p % GW;
        return (r == 0) || (r == GH - 1) || (c == 0) || (c == GW - 1);
    endfunction

    task automatic model_reset();
        m_active = 0; m_complete = 0; m_done = 0; m_pos = 0; m_results = 0;
    endtask

    task automatic tick(input bit st, input logic [15:0] emp, input bit stl, input bit rv);
        int  p;
        bit  scanning, ready, e_cv, e_pad, e_rd;
        bus.start = st; bus.fifo_empty = emp; bus.stall = stl; bus.result_valid = rv;
        #1;
        p        = m_complete ? NPOS - 1 : m_pos;
        scanning = m_active && !m_complete && !m_done;
        ready    = (emp == 16'h0);
        e_cv     = scanning && !stl && (is_border(p) || ready);
        e_pad    = e_cv && is_border(p);
        e_rd     = scanning && !stl && !is_border(p) && ready;
        check("conv_valid", bus.conv_valid, e_cv);
        check("pad_sel",    bus.pad_sel,    e_pad);
        check("fifo_rdreq", bus.fifo_rdreq, e_rd);
        check("row_cnt",    bus.row_cnt,    p / GW);
        check("col_cnt",    bus.col_cnt,    p % GW);
        check("busy",       bus.busy,       m_active);
        check("done",       bus.done,       m_done);
        if (bus.conv_valid === 1'b1) n_cv++;
        if (bus.pad_sel === 1'b1) n_pad++;
        if (bus.fifo_rdreq === 1'b1) begin
            if (first_rd_row < 0) begin
                first_rd_row = int'(bus.row_cnt);
                first_rd_col = int'(bus.col_cnt);
            end
            n_rd++;
        end
        @(posedge clk);
        if (m_done) begin
            m_done = 0; m_active = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_pos = 0; m_complete = 0; m_results = 0;
            end
        end else begin
            if (rv && m_results < NRES) m_results++;
            if (!m_complete) begin
                if (e_cv) begin
                    if (m_pos == NPOS - 1) m_complete = 1;
                    else m_pos++;
                end
            end else if (m_results == NRES) begin
                m_done = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic start_frame();
        n_cv = 0; n_rd = 0; n_pad = 0; first_rd_row = -1; first_rd_col = -1;
        tick(1'b1, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_cv_total"},  n_cv,  NPOS);
        check({tag, "_rd_total"},  n_rd,  NRES);
        check({tag, "_pad_total"}, n_pad, NPAD);
    endtask

    task automatic finish_frame(input string tag, input bit random_start);
        int k = 0;
        while (m_active && k < 400) begin
            tick(random_start ? 1'($urandom_range(0, 1)) : 1'b0, 16'h0, 1'b0,
                 1'($urandom_range(0, 1)));
            k++;
        end
        check({tag, "_frame_timeout"}, m_active, 0);
    endtask

    task automatic abort_now();
        #2 rst = 1'b0;
        #1;
        check("abort_row",  bus.row_cnt,    0);
        check("abort_col",  bus.col_cnt,    0);
        check("abort_busy", bus.busy,       0);
        check("abort_done", bus.done,       0);
        check("abort_cv",   bus.conv_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   stalled;
        int   k;
        logic [15:0] emp;
        bus.start = 0; bus.fifo_empty = '0; bus.stall = 0; bus.result_valid = 0;
        model_reset();
        n_cv = 0; n_rd = 0; n_pad = 0; first_rd_row = -1; first_rd_col = -1;

        // reset state
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_row",  bus.row_cnt, 0);
        check("reset_col",  bus.col_cnt, 0);
        check("reset_cv",   bus.conv_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 16'h0, 1'b0, 1'b1);

        // nominal frame
        start_frame();
        finish_frame("nominal", 1'b0);
        check_totals("nominal");
        check("first_rd_row", first_rd_row, 1);
        check("first_rd_col", first_rd_col, 1);
        tick(1'b0, 16'h0, 1'b0, 1'b0);

        // empty gating on one channel at row 1, col 2
        start_frame();
        k = 0;
        while (m_pos != GW + 2 && k < 50) begin tick(1'b0, 16'h0, 1'b0, 1'b0); k++; end
        repeat (5) tick(1'b0, 16'h0080, 1'b0, 1'b0);
        check("gate_row", bus.row_cnt, 1);
        check("gate_col", bus.col_cnt, 2);
        check("gate_rd_total", n_rd, 1);
        finish_frame("gate", 1'b0);
        check_totals("gate");

        // all FIFOs empty: only border positions advance
        start_frame();
        repeat (12) tick(1'b0, 16'hFFFF, 1'b0, 1'b0);
        check("border_pad", n_pad, GW + 1);
        check("border_cv",  n_cv,  GW + 1);
        check("border_rd",  n_rd,  0);
        check("border_row", bus.row_cnt, 1);
        check("border_col", bus.col_cnt, 1);
        abort_now();

        // random stall / empty pattern with a fixed 3-cycle stall mid-row
        start_frame();
        stalled = 0;
        k = 0;
        while (m_active && k < 600) begin
            if (m_pos == 2 * GW + 2 && !stalled) begin
                repeat (3) tick(1'b0, 16'h0, 1'b1, 1'b0);
                check("stall_col", bus.col_cnt, 2);
                stalled = 1;
            end
            emp = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            tick(1'b0, emp, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0));
            k++;
        end
        check("stall_frame_timeout", m_active, 0);
        check_totals("stall");

        // result accounting: 11 in scan, 12th late in drain, then extras
        start_frame();
        repeat (11) tick(1'b0, 16'h0, 1'b0, 1'b1);
        k = 0;
        while (!m_complete && k < 100) begin tick(1'b0, 16'h0, 1'b0, 1'b0); k++; end
        check("acct_scan_end", m_complete, 1);
        repeat (20) tick(1'b0, 16'h0, 1'b0, 1'b0);
        check("acct_waiting", bus.busy, 1);
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        check("acct_done_next", bus.done, 1);
        repeat (3) tick(1'b0, 16'h0, 1'b0, 1'b1);
        check("acct_idle", bus.busy, 0);

        // abort at row 2, col 3 and restart with start pulses while busy
        start_frame();
        k = 0;
        while (m_pos != 2 * GW + 3 && k < 50) begin
            tick(1'($urandom_range(0, 1)), 16'h0, 1'b0, 1'b0);
            k++;
        end
        check("abort_pos_row", bus.row_cnt, 2);
        check("abort_pos_col", bus.col_cnt, 3);
        abort_now();
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        start_frame();
        finish_frame("restart", 1'b1);
        check_totals("restart");
        tick(1'b0, 16'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
